// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and types for the FP writeback/scoreboard slice
//
// Purpose: register-file geometry and the writeback/exception-flag types
//          shared by fp_writeback_sb and fp_scoreboard.
// Contents:
//   FLEN     - FP data width
//   NREG     - number of FP registers
//   AW       - register address width
//   fflags_t - IEEE exception flags {nv,dz,of,uf,nx}
//   wb_req_t - one register-file write request {rd, data}

package fp_pkg;

  localparam int FLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [FLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/fp_scoreboard.sv
// rtl/fp_scoreboard.sv - per-register pending bits, hazard stall and stray-writeback error
//
// Purpose: tracks which FP registers have an in-flight result and stalls
//          issue on RAW/WAW hazards against them.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   issue_valid/we/rd/rs1..rs3  instruction presented by decode
//   issue_rs_used               bit k set means rs(k+1) is read
//   issue_stall                 hazard on the presented instruction
//   clr_en, clr_rd              registered write port; clears pending bit
//   wb_en, wb_rd                writeback accepted this cycle (error check)
//   sb_err                      sticky: writeback to a non-pending register

module fp_scoreboard
  import fp_pkg::*;
#(
  parameter int SB_NREG = fp_pkg::NREG,
  parameter int SB_AW   = fp_pkg::AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [SB_AW-1:0] issue_rd,
  input  logic [SB_AW-1:0] issue_rs1,
  input  logic [SB_AW-1:0] issue_rs2,
  input  logic [SB_AW-1:0] issue_rs3,
  input  logic [2:0]       issue_rs_used,
  output logic             issue_stall,
  input  logic             clr_en,
  input  logic [SB_AW-1:0] clr_rd,
  input  logic             wb_en,
  input  logic [SB_AW-1:0] wb_rd,
  output logic             sb_err
);

  logic [SB_NREG-1:0] pending;
  logic               raw_hit;
  logic               waw_hit;
  logic               set_en;

  always_comb begin
    raw_hit = (issue_rs_used[0] && pending[issue_rs1]) ||
              (issue_rs_used[1] && pending[issue_rs2]) ||
              (issue_rs_used[2] && pending[issue_rs3]);
    waw_hit = issue_we && pending[issue_rd];
  end

  assign issue_stall = issue_valid && (raw_hit || waw_hit);
  assign set_en      = issue_valid && issue_we && !issue_stall;

  // The clear follows the registered write port, so it lands on the same edge
  // the register file captures the data. The set is written last so it wins a
  // same-register collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (clr_en) begin
        pending[clr_rd] <= 1'b0;
      end
      if (set_en) begin
        pending[issue_rd] <= 1'b1;
      end
    end
  end

  // Checked at acceptance; the pending bit is still set then because its
  // clear happens one edge later, from the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (wb_en && !pending[wb_rd]) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fp_writeback_sb.sv
// rtl/fp_writeback_sb.sv - FP writeback arbiter, output register, sticky fflags and scoreboard
//
// Purpose: merges FPU and load results into the single FP register-file
//          write port, accumulates IEEE flags and stalls hazardous issue.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   issue_*                       decode instruction; issue_stall_o on hazard
//   fpu_valid_i/ready_o/rd/result/fflags   FPU result handshake
//   lsu_valid_i/rd/data           load result, never back-pressured
//   fflags_clr_i                  CSR clear of the sticky flags
//   fregwrite_o/frd_o/writeback_data_o     register-file write port
//   fflags_o                      sticky accumulated flags
//   sb_err_o                      sticky stray-writeback error

module fp_writeback_sb
  import fp_pkg::*;
#(
  parameter int FLEN = fp_pkg::FLEN,
  parameter int NREG = fp_pkg::NREG,
  parameter int AW   = fp_pkg::AW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            issue_valid_i,
  input  logic            issue_we_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic [AW-1:0]   issue_rs1_i,
  input  logic [AW-1:0]   issue_rs2_i,
  input  logic [AW-1:0]   issue_rs3_i,
  input  logic [2:0]      issue_rs_used_i,
  output logic            issue_stall_o,
  input  logic            fpu_valid_i,
  output logic            fpu_ready_o,
  input  logic [AW-1:0]   fpu_rd_i,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_fflags_i,
  input  logic            lsu_valid_i,
  input  logic [AW-1:0]   lsu_rd_i,
  input  logic [FLEN-1:0] lsu_data_i,
  input  logic            fflags_clr_i,
  output logic            fregwrite_o,
  output logic [AW-1:0]   frd_o,
  output logic [FLEN-1:0] writeback_data_o,
  output logic [4:0]      fflags_o,
  output logic            sb_err_o
);

  logic            fpu_accept;
  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [FLEN-1:0] wb_data;
  fflags_t         fflags_q;

  // Loads cannot be stalled, so they always win; the FPU holds its result.
  assign fpu_ready_o = !lsu_valid_i;
  assign fpu_accept  = fpu_valid_i && fpu_ready_o;
  assign wb_en       = lsu_valid_i || fpu_accept;
  assign wb_rd       = lsu_valid_i ? lsu_rd_i   : fpu_rd_i;
  assign wb_data     = lsu_valid_i ? lsu_data_i : fpu_result_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fregwrite_o      <= 1'b0;
      frd_o            <= '0;
      writeback_data_o <= '0;
    end else begin
      fregwrite_o <= wb_en;
      if (wb_en) begin
        frd_o            <= wb_rd;
        writeback_data_o <= wb_data;
      end
    end
  end

  // A clear coinciding with an FPU accept keeps only the new result's flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else if (fflags_clr_i) begin
      fflags_q <= fpu_accept ? fflags_t'(fpu_fflags_i) : fflags_t'(5'b0);
    end else if (fpu_accept) begin
      fflags_q <= fflags_t'(fflags_q | fpu_fflags_i);
    end
  end

  assign fflags_o = fflags_q;

  fp_scoreboard #(
    .SB_NREG (NREG),
    .SB_AW   (AW)
  ) u_scoreboard (
    .clk           (clk_i),
    .rst_n         (rst_ni),
    .issue_valid   (issue_valid_i),
    .issue_we      (issue_we_i),
    .issue_rd      (issue_rd_i),
    .issue_rs1     (issue_rs1_i),
    .issue_rs2     (issue_rs2_i),
    .issue_rs3     (issue_rs3_i),
    .issue_rs_used (issue_rs_used_i),
    .issue_stall   (issue_stall_o),
    .clr_en        (fregwrite_o),
    .clr_rd        (frd_o),
    .wb_en         (wb_en),
    .wb_rd         (wb_rd),
    .sb_err        (sb_err_o)
  );

endmodule

// File: doc/fp_writeback_sb.md
Name: fp_writeback_sb

Overview:
- Writeback and scoreboard stage directly upstream of the FP register file.
- Merges results from the multi-cycle FPU and from the load unit into the register file's single write port (fregwrite/frd/writeback_data).
- Tracks a pending bit per FP register so issue stalls on RAW and WAW hazards against in-flight results.
- Accumulates sticky IEEE exception flags (fflags).

Parameters:
- FLEN, 32, FP data width.
- NREG, 32, number of FP registers.
- AW, 5, register address width, equal to $clog2(NREG).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  decode presents an FP-related instruction.
- issue_we_i  in  1  instruction writes an FP register.
- issue_rd_i  in  AW  destination register.
- issue_rs1_i, issue_rs2_i, issue_rs3_i  in  AW each  source registers.
- issue_rs_used_i  in  3  bit k set means rs(k+1) is read.
- issue_stall_o  out  1  hazard; instruction must not issue this cycle.
- fpu_valid_i  in  1  FPU result available.
- fpu_ready_o  out  1  FPU result accepted this cycle.
- fpu_rd_i  in  AW  FPU result destination.
- fpu_result_i  in  FLEN  FPU result data.
- fpu_fflags_i  in  5  NV,DZ,OF,UF,NX for this result.
- lsu_valid_i  in  1  FP load data available; cannot be back-pressured.
- lsu_rd_i  in  AW  load destination.
- lsu_data_i  in  FLEN  load data.
- fflags_clr_i  in  1  clear the sticky flags (CSR write).
- fregwrite_o  out  1  register-file write enable.
- frd_o  out  AW  register-file write address.
- writeback_data_o  out  FLEN  register-file write data.
- fflags_o  out  5  sticky accumulated flags.
- sb_err_o  out  1  sticky: writeback arrived to a non-pending register.

Behaviour:
- Reset, asynchronous and active-low: fregwrite_o=0, frd_o=0, writeback_data_o=0, fflags_o=0, sb_err_o=0, all pending bits=0. Reset mid-operation discards in-flight results; no write is produced after reset.
- Arbitration (combinational, in cycle N):
  - lsu_valid_i has strict priority.
  - fpu_ready_o = !lsu_valid_i.
  - An FPU result is accepted when fpu_valid_i && fpu_ready_o.
  - The FPU holds rd, result and fflags stable while valid && !ready.
- Output register: one-cycle latency. The winner is loaded into fregwrite_o/frd_o/writeback_data_o at the edge ending cycle N. With no winner, fregwrite_o=0 and frd_o/writeback_data_o hold their previous values.
- fflags:
  - On an accepted FPU result, fflags_o |= fpu_fflags_i at the same edge.
  - Loads never touch fflags.
  - If fflags_clr_i and an FPU accept occur in the same cycle: fflags_o = fpu_fflags_i (the clear applies first, then the new flags).
- Scoreboard, pending[NREG]:
  - Set: pending[issue_rd_i] is set when issue_valid_i && issue_we_i && !issue_stall_o.
  - Clear: pending[frd_o] is cleared at the edge ending a cycle with fregwrite_o=1. This is the same edge on which the register file captures the data, so a reader unstalled in the next cycle sees the new value. No bypass path exists.
  - If set and clear hit the same register on the same edge, set wins. This cannot occur legally, because the WAW check stalls such an issue.
- issue_stall_o (combinational from the registered pending bits):
  - issue_valid_i && ( (rs_used[0] && pending[rs1]) || (rs_used[1] && pending[rs2]) || (rs_used[2] && pending[rs3]) || (issue_we_i && pending[rd]) ).
- Error: if an accepted writeback targets a register whose pending bit is 0, sb_err_o sets and stays set until reset. The data is still written.
- Register f0 is an ordinary register with no special casing.

Decomposition:
- Shared package fp_pkg holds:
  - constants FLEN, NREG, AW;
  - typedef fflags_t, a packed struct {nv,dz,of,uf,nx};
  - typedef wb_req_t {rd, data}.
- One natural sub-module, fp_scoreboard: owns the pending vector, set/clear logic, stall compare and sb_err.
- The arbiter, output register and fflags logic stay in the top level.

Test Plan:
- Reset then idle: all outputs 0. Issue rd=3, we=1, rs_used=0 → no stall, pending[3]=1.
- RAW: after the rd=3 issue, issue rs1=3, rs_used=001 → stall=1. FPU returns rd=3, data 0x40400000 → fregwrite_o=1, frd_o=3 the next cycle. Stall drops the cycle after that.
- Conflict: lsu_valid rd=5 and fpu_valid rd=7 in the same cycle → fpu_ready_o=0. Writes occur in order rd=5 then rd=7 on consecutive cycles, with the FPU data held stable.
- fflags: FPU results with flags 00001 then 10000 → fflags_o=10001. Clear coincident with flags 00100 → fflags_o=00100.
- WAW: pending[9] set; issue rd=9, we=1 → stall=1 until the rd=9 writeback completes.
- Stray writeback: an LSU write to rd=12 with pending[12]=0 → sb_err_o=1 and the write still occurs. Asserting rst_ni=0 mid-burst → all outputs 0 immediately.
